// File: rtl/fusioncap_pool_scheduler.sv
// Fusion-CAP pooling scheduler: fetches 10-sample groups, runs the averaging PE, writes results.
// Optional FUSIONCAP_SCHED_RELU_EN clamps negative PE results to zero on the write path.
module fusioncap_pool_scheduler #(
  parameter int ADDR_W = 10,
  parameter int GRP_W  = 6,
  parameter int PE_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [GRP_W-1:0]  cmd_groups,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              pe_start,
  output logic [159:0]      pe_x,
  input  logic [15:0]       pe_odata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RD, START, WAIT_PE, WRITE, FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [GRP_W-1:0]   groups_q;
  logic [GRP_W-1:0]   grp;
  logic [ADDR_W-1:0]  base;
  logic [3:0]         k;
  logic [CNT_W-1:0]   pe_cnt;
  logic               last_grp;

  assign last_grp = (grp == groups_q - GRP_W'(1));

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    pe_start  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = (cmd_groups == '0) ? FINISH : FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        // base tracks grp*10 so the address wraps naturally at ADDR_W
        rd_addr = base + ADDR_W'(k);
        if (k == 4'd9) state_nxt = WAIT_RD;
      end
      WAIT_RD: state_nxt = START;
      START: begin
        pe_start  = 1'b1;
        state_nxt = WAIT_PE;
      end
      WAIT_PE: begin
        if (pe_cnt == CNT_W'(PE_LAT - 1)) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(grp);
`ifdef FUSIONCAP_SCHED_RELU_EN
        wr_data = pe_odata[15] ? 16'd0 : pe_odata;
`else
        wr_data = pe_odata;
`endif
        state_nxt = last_grp ? FINISH : FETCH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      groups_q <= '0;
      grp      <= '0;
      base     <= '0;
      k        <= '0;
      pe_cnt   <= '0;
      pe_x     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            groups_q <= cmd_groups;
            grp      <= '0;
            base     <= '0;
            k        <= '0;
          end
        end
        FETCH: begin
          // sample read in cycle k-1 arrives now and lands in slot k-1
          if (k != 4'd0) pe_x[{k - 4'd1, 4'b0000} +: 16] <= rd_data;
          k <= (k == 4'd9) ? 4'd0 : k + 4'd1;
        end
        WAIT_RD: begin
          pe_x[159:144] <= rd_data;
          pe_cnt        <= '0;
        end
        WAIT_PE: pe_cnt <= pe_cnt + CNT_W'(1);
        WRITE: begin
          if (!last_grp) begin
            grp  <= grp + GRP_W'(1);
            base <= base + ADDR_W'(10);
            k    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fusioncap_pool_scheduler.sv
// Bench for fusioncap_pool_scheduler: sample RAM and PE models, queue-based monitor, directed and random commands.
module tb_fusioncap_pool_scheduler;

  localparam int ADDR_W = 10;
  localparam int GRP_W  = 6;
  localparam int PE_LAT = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [GRP_W-1:0]  cmd_groups = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data = '0;
  logic              pe_start;
  logic [159:0]      pe_x;
  logic [15:0]       pe_odata;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;

  fusioncap_pool_scheduler #(.ADDR_W(ADDR_W), .GRP_W(GRP_W), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_groups(cmd_groups),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pe_start(pe_start), .pe_x(pe_x), .pe_odata(pe_odata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic signed [15:0] mem [1024];

  typedef struct {
    int          c;
    int          addr;
    logic [15:0] dat;
  } wr_t;

  wr_t wr_q[$];
  int  rd_q[$];
  int  done_q[$];
  int  start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // PE: truncating average of the ten inputs, valid PE_LAT clocks after the start edge
  logic [15:0] pe_res = 16'hDEAD;
  int          pe_left = 0;

  function automatic logic [15:0] pe_avg(input logic [159:0] x);
    int s = 0;
    for (int i = 0; i < 10; i++) s += int'($signed(x[16*i +: 16]));
    return 16'(s / 10);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pe_res  <= 16'hDEAD;
      pe_left <= 0;
    end else if (pe_start) begin
      pe_res  <= pe_avg(pe_x);
      pe_left <= PE_LAT;
    end else if (pe_left != 0) begin
      pe_left <= pe_left - 1;
    end
  end

  assign pe_odata = (pe_left == 0) ? pe_res : 16'hDEAD;

  always @(negedge clk) begin
    if (wr_en)    wr_q.push_back('{cyc, int'(wr_addr), wr_data});
    if (rd_en)    rd_q.push_back(int'(rd_addr));
    if (done)     done_q.push_back(cyc);
    if (pe_start) start_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    start_q.delete();
  endtask

  function automatic logic [15:0] ref_avg(input int g);
    int s = 0;
    int a;
    for (int k = 0; k < 10; k++) s += int'(mem[(g * 10 + k) % 1024]);
    a = s / 10;
`ifdef FUSIONCAP_SCHED_RELU_EN
    if (a < 0) a = 0;
`endif
    return 16'(a);
  endfunction

  // Issues one command, waits for completion and compares the whole trace with the reference
  task automatic run_cmd(input int n, input bit extra_valid);
    int acc;
    int waited;
    clear_mon();
    cmd_groups = GRP_W'(n);
    cmd_valid  = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(cmd_ready), 32'd1);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
    if (extra_valid) begin
      repeat (3) tick();
      cmd_valid  = 1'b1;
      cmd_groups = GRP_W'(5);
      @(negedge clk);
      check("ready_low_when_busy", 32'(cmd_ready), 32'd0);
      tick();
      cmd_valid = 1'b0;
    end
    waited = 0;
    while (done_q.size() == 0 && waited < 18 * 64 + 20) begin
      tick();
      waited++;
    end
    check("done_seen", 32'(done_q.size() > 0), 32'd1);
    if (done_q.size() > 0) check("done_cycle", 32'(done_q[0] - acc), 32'(18 * n + 1));
    repeat (4) tick();
    check("idle_after_done", 32'({busy, cmd_ready}), 32'b01);
    check("done_count", 32'(done_q.size()), 32'd1);
    check("wr_count", 32'(wr_q.size()), 32'(n));
    check("rd_count", 32'(rd_q.size()), 32'(10 * n));
    check("pe_start_count", 32'(start_q.size()), 32'(n));
    for (int g = 0; g < n && g < wr_q.size(); g++) begin
      check("wr_addr", 32'(wr_q[g].addr), 32'(g));
      check("wr_data", 32'(wr_q[g].dat), 32'(ref_avg(g)));
      check("wr_cycle", 32'(wr_q[g].c - acc), 32'(18 * (g + 1)));
    end
    for (int i = 0; i < rd_q.size() && i < 10 * n; i++)
      check("rd_addr", 32'(rd_q[i]), 32'(i % 1024));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int waited;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    repeat (3) tick();
    check("rst_ready_busy", 32'({cmd_ready, busy}), 32'b10);
    check("rst_strobes", 32'({rd_en, wr_en, pe_start, done}), 32'd0);
    check("rst_pe_x_zero", 32'(pe_x == '0), 32'd1);
    check("rst_addr_data", 32'({rd_addr, wr_addr, wr_data}), 32'd0);
    rst = 1'b0;
    tick();

    // samples 1..10 average to 5
    for (int k = 0; k < 10; k++) mem[k] = 16'(k + 1);
    run_cmd(1, 1'b0);

    for (int k = 0; k < 10; k++) mem[k] = -16'sd7;
    run_cmd(1, 1'b0);

    for (int k = 0; k < 10; k++) mem[k] = 16'sd32767;
    run_cmd(1, 1'b0);
    for (int k = 0; k < 10; k++) mem[k] = -16'sd32768;
    run_cmd(1, 1'b0);

    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 10; k++) mem[g * 10 + k] = 16'(g + 1);
    run_cmd(3, 1'b0);

    run_cmd(0, 1'b0);

    // second request during FETCH must be dropped
    run_cmd(2, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 100; i++) mem[i] = 16'($urandom);
      run_cmd(int'($urandom_range(1, 8)), 1'b0);
    end
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    run_cmd(63, 1'b0);

    // abort during WAIT_PE of group 0
    clear_mon();
    cmd_groups = GRP_W'(2);
    cmd_valid  = 1'b1;
    @(negedge clk);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
    waited = 0;
    while (cyc != acc + 14 && waited < 50) begin
      tick();
      waited++;
    end
    check("reach_wait_pe", 32'(cyc - acc), 32'd14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready_busy", 32'({cmd_ready, busy}), 32'b10);
    check("abort_strobes", 32'({rd_en, wr_en, pe_start, done}), 32'd0);
    check("abort_pe_x_zero", 32'(pe_x == '0), 32'd1);
    repeat (40) tick();
    check("abort_no_write", 32'(wr_q.size()), 32'd0);
    check("abort_no_done", 32'(done_q.size()), 32'd0);
    check("abort_reads", 32'(rd_q.size()), 32'd10);
    check("abort_idle", 32'({cmd_ready, busy}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
